hazard_controller: RTL

- Sequences the five-stage MIPS pipeline around the instruction-decode stage.
- Detects load-use hazards between the ID operands and the load in EX.
- Flushes wrong-path instructions after a taken branch or jump.
- Freezes the pipeline while data memory is busy. Drives PC, IF/ID and ID/EX register enables/bubbles; holds no datapath state itself.

---
 rtl/mips_pipe_pkg.sv | 13 +
 rtl/hazard_controller_if.sv | 40 ++++
 rtl/load_use_detect.sv | 25 ++
 rtl/hazard_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the MIPS decode, execute and hazard-control logic.
package mips_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// ID/EX hazard inputs and pipeline-control outputs of the hazard controller.
interface hazard_controller_if
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_memRead;
    logic [ADDR_W-1:0] ex_regAddr;
    logic              branch_taken;
    logic              mem_busy;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              pipe_hold;
    pipe_state_e       state;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, ex_memRead, ex_regAddr,
               branch_taken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               state, stall_cycles, flush_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, ex_memRead, ex_regAddr,
               branch_taken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               state, stall_cycles, flush_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Pure comparator: flags an ID operand that depends on the load currently in EX.
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              i_id_valid,
    input  logic [ADDR_W-1:0] i_id_rs,
    input  logic [ADDR_W-1:0] i_id_rt,
    input  logic              i_id_uses_rt,
    input  logic              i_ex_mem_read,
    input  logic [ADDR_W-1:0] i_ex_reg_addr,
    output logic              o_hazard
);
    logic w_dest_live;
    logic w_rs_match;
    logic w_rt_match;

    // Writes to $zero never create a dependency.
    assign w_dest_live = i_ex_mem_read && (i_ex_reg_addr != ADDR_W'(REG_ZERO));
    assign w_rs_match  = (i_ex_reg_addr == i_id_rs);
    assign w_rt_match  = i_id_uses_rt && (i_ex_reg_addr == i_id_rt);
    assign o_hazard    = i_id_valid && w_dest_live && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use stalls, branch flushes and memory-busy freezes.
// Optional saturating stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    hazard_controller_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    pipe_state_e     r_state;
    pipe_state_e     r_saved;
    logic [FC_W-1:0] r_cnt;
    logic            r_pend;

    pipe_state_e     w_state_nxt;
    pipe_state_e     w_saved_nxt;
    pipe_state_e     w_eff;
    logic [FC_W-1:0] w_cnt_nxt;
    logic            w_pend_nxt;
    logic            w_br;
    logic            w_hazard;
    logic            w_pc_write;
    logic            w_ifid_write;
    logic            w_ifid_flush;
    logic            w_idex_bubble;
    logic            w_pipe_hold;
    logic            w_stall;
    logic            w_br_bubble;

    load_use_detect #(.ADDR_W(ADDR_W)) u_load_use_detect (
        .i_id_valid   (bus.id_valid),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .i_id_uses_rt (bus.id_uses_rt),
        .i_ex_mem_read(bus.ex_memRead),
        .i_ex_reg_addr(bus.ex_regAddr),
        .o_hazard     (w_hazard)
    );

    // FSM state, flush countdown, saved resume state and deferred branch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= RUN;
            r_saved <= RUN;
            r_cnt   <= {FC_W{1'b0}};
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state and enables; the first free MEM_WAIT cycle behaves as the state it resumes.
    always_comb begin
        w_state_nxt   = r_state;
        w_saved_nxt   = r_saved;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_hold   = 1'b0;
        w_stall       = 1'b0;
        w_br_bubble   = 1'b0;
        w_eff         = r_state;
        w_br          = bus.branch_taken;

        if ((r_state == MEM_WAIT) && !bus.mem_busy) begin
            if (r_pend) begin
                w_eff      = RUN;
                w_br       = 1'b1;
                w_pend_nxt = 1'b0;
            end else begin
                w_eff = r_saved;
            end
        end else begin
            w_eff = r_state;
        end

        if (bus.mem_busy) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
            w_pend_nxt   = r_pend | bus.branch_taken;
            w_state_nxt  = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_saved_nxt = r_state;
            end else begin
                w_saved_nxt = r_saved;
            end
        end else begin
            case (w_eff)
                RUN: begin
                    w_state_nxt = RUN;
                    if (w_br) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                        w_br_bubble   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_cnt_nxt   = FC_RELOAD;
                            w_state_nxt = FLUSH;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end else if (w_hazard) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_stall       = 1'b1;
                    end else begin
                        w_stall = 1'b0;
                    end
                end
                FLUSH: begin
                    w_ifid_flush  = 1'b1;
                    w_idex_bubble = 1'b1;
                    w_br_bubble   = 1'b1;
                    if (w_br) begin
                        w_cnt_nxt   = FC_RELOAD;
                        w_state_nxt = FLUSH;
                    end else if (r_cnt <= FC_W'(1'b1)) begin
                        w_cnt_nxt   = {FC_W{1'b0}};
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt   = r_cnt - FC_W'(1'b1);
                        w_state_nxt = FLUSH;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // Reset forces the pipeline into a safe NOP-injecting configuration.
    assign bus.pc_write    = reset ? w_pc_write    : 1'b0;
    assign bus.ifid_write  = reset ? w_ifid_write  : 1'b0;
    assign bus.ifid_flush  = reset ? w_ifid_flush  : 1'b1;
    assign bus.idex_bubble = reset ? w_idex_bubble : 1'b1;
    assign bus.pipe_hold   = reset ? w_pipe_hold   : 1'b0;
    assign bus.state       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating stall and branch-bubble counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
            end
            if (w_br_bubble && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1'b1);
            end
        end
    end

    assign bus.stall_cycles = r_stall_cnt;
    assign bus.flush_cycles = r_flush_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf    = w_stall ^ w_br_bubble;
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_cycles = {CNT_W{1'b0}};
`endif

endmodule
